rf_wport_arbiter: RTL and testbench

RF_WPORT_ARBITER -- requirements
Module: rf_wport_arbiter

---
 rtl/rf_wport_arbiter.sv | 115 +++++++++++
 tb/tb_rf_wport_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// Shares the single RegFile write port between the WB stage and a small in-order
// multiply/divide result buffer, with WB-starvation relief and ID-stage bypass.
module rf_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_w_en,
    input  logic [4:0]                 wb_w_addr,
    input  logic [31:0]                wb_w_data,
    output logic                       wb_stall,
    input  logic                       md_valid,
    input  logic [4:0]                 md_w_addr,
    input  logic [31:0]                md_w_data,
    output logic                       md_ready,
    output logic                       rf_w_en,
    output logic [4:0]                 rf_w_addr,
    output logic [31:0]                rf_w_data,
    input  logic [4:0]                 rd_addr1,
    input  logic [4:0]                 rd_addr2,
    output logic                       byp_hit1,
    output logic [31:0]                byp_data1,
    output logic                       byp_hit2,
    output logic [31:0]                byp_data2,
    output logic [$clog2(DEPTH):0]     buf_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    logic [4:0]       buf_addr [DEPTH];
    logic [31:0]      buf_data [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [ST_W-1:0]  starve_cnt;
    logic             ready_en;
    logic             wb_grant;
    logic             wb_wr;
    logic             pop;
    logic             push;

    assign buf_count = count;
    // ready_en holds md_ready low until the first edge after reset releases
    assign md_ready  = ready_en && (count < CNT_W'(DEPTH));

    always_comb begin
        wb_stall = (starve_cnt == ST_W'(STARVE_MAX)) && (count != '0);
        wb_grant = wb_w_en && !wb_stall;
        wb_wr    = wb_grant && (wb_w_addr != 5'd0) && !reset;
        pop      = !wb_grant && (count != '0) && !reset;
        push     = md_valid && md_ready && (md_w_addr != 5'd0);
    end

    always_comb begin
        rf_w_en   = wb_wr || pop;
        rf_w_addr = 5'd0;
        rf_w_data = 32'd0;
        if (wb_wr) begin
            rf_w_addr = wb_w_addr;
            rf_w_data = wb_w_data;
        end else if (pop) begin
            rf_w_addr = buf_addr[rd_ptr];
            rf_w_data = buf_data[rd_ptr];
        end
    end

    // Walk oldest to youngest so the youngest matching entry wins
    always_comb begin
        byp_hit1  = 1'b0;
        byp_data1 = 32'd0;
        byp_hit2  = 1'b0;
        byp_data2 = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count) && (rd_addr1 != 5'd0) &&
                (buf_addr[rd_ptr + PTR_W'(k)] == rd_addr1)) begin
                byp_hit1  = 1'b1;
                byp_data1 = buf_data[rd_ptr + PTR_W'(k)];
            end
            if ((CNT_W'(k) < count) && (rd_addr2 != 5'd0) &&
                (buf_addr[rd_ptr + PTR_W'(k)] == rd_addr2)) begin
                byp_hit2  = 1'b1;
                byp_data2 = buf_data[rd_ptr + PTR_W'(k)];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            ready_en   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if ((count == '0) || pop)
                starve_cnt <= '0;
            else if (wb_grant && (starve_cnt < ST_W'(STARVE_MAX)))
                starve_cnt <= starve_cnt + ST_W'(1);
        end
    end

    // Entry contents need no reset; validity comes from the pointers and count
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= md_w_addr;
            buf_data[wr_ptr] <= md_w_data;
        end
    end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed vector table, reset sequences,
// and random traffic against a queue-based reference model.
module tb_rf_wport_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             wb_w_en;
    logic [4:0]       wb_w_addr;
    logic [31:0]      wb_w_data;
    logic             wb_stall;
    logic             md_valid;
    logic [4:0]       md_w_addr;
    logic [31:0]      md_w_data;
    logic             md_ready;
    logic             rf_w_en;
    logic [4:0]       rf_w_addr;
    logic [31:0]      rf_w_data;
    logic [4:0]       rd_addr1;
    logic [4:0]       rd_addr2;
    logic             byp_hit1;
    logic [31:0]      byp_data1;
    logic             byp_hit2;
    logic [31:0]      byp_data2;
    logic [CNT_W-1:0] buf_count;

    rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .wb_w_en(wb_w_en), .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data), .wb_stall(wb_stall),
        .md_valid(md_valid), .md_w_addr(md_w_addr), .md_w_data(md_w_data), .md_ready(md_ready),
        .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .byp_hit1(byp_hit1), .byp_data1(byp_data1), .byp_hit2(byp_hit2), .byp_data2(byp_data2),
        .buf_count(buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] r1, input logic [4:0] r2);
        wb_w_en = we; wb_w_addr = wa; wb_w_data = wd;
        md_valid = mv; md_w_addr = ma; md_w_data = md;
        rd_addr1 = r1; rd_addr2 = r2;
    endtask

    typedef struct {
        logic wb_en; logic [4:0] wb_addr; logic [31:0] wb_data;
        logic md_v;  logic [4:0] md_addr; logic [31:0] md_data;
        logic [4:0] rd1; logic [4:0] rd2;
        logic e_en; logic [4:0] e_addr; logic [31:0] e_data;
        logic e_rdy; logic e_stall; logic [CNT_W-1:0] e_cnt;
        logic e_h1; logic [31:0] e_d1; logic e_h2; logic [31:0] e_d2;
    } vec_t;
    vec_t tv[$];

    // Reference model: FIFO contents as a queue, starvation as a plain count
    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t m_q[$];
    int   m_starve;
    bit   m_ready_en;

    task automatic model_cycle();
        int  cnt;
        bit  stall, rdy, wbg, pop_h, e_en, h1, h2;
        logic [4:0]  e_a;
        logic [31:0] e_d, d1, d2;
        ent_t e;
        cnt   = m_q.size();
        stall = (m_starve == STARVE_MAX) && (cnt > 0);
        rdy   = m_ready_en && (cnt < DEPTH);
        wbg   = wb_w_en && !stall;
        pop_h = !wbg && (cnt > 0);
        e_en  = (wbg && wb_w_addr != 5'd0) || pop_h;
        e_a   = 5'd0;
        e_d   = 32'd0;
        if (wbg && wb_w_addr != 5'd0) begin e_a = wb_w_addr; e_d = wb_w_data; end
        else if (pop_h) begin e_a = m_q[0].a; e_d = m_q[0].d; end
        h1 = 1'b0; d1 = 32'd0; h2 = 1'b0; d2 = 32'd0;
        for (int i = cnt - 1; i >= 0; i--) begin
            if (!h1 && rd_addr1 != 5'd0 && m_q[i].a == rd_addr1) begin h1 = 1'b1; d1 = m_q[i].d; end
            if (!h2 && rd_addr2 != 5'd0 && m_q[i].a == rd_addr2) begin h2 = 1'b1; d2 = m_q[i].d; end
        end
        chk("rnd_rf_w_en", {31'd0, rf_w_en}, {31'd0, e_en});
        if (e_en) begin
            chk("rnd_rf_w_addr", {27'd0, rf_w_addr}, {27'd0, e_a});
            chk("rnd_rf_w_data", rf_w_data, e_d);
        end
        chk("rnd_md_ready", {31'd0, md_ready}, {31'd0, rdy});
        chk("rnd_wb_stall", {31'd0, wb_stall}, {31'd0, stall});
        chk("rnd_buf_count", 32'(buf_count), 32'(cnt));
        chk("rnd_byp_hit1", {31'd0, byp_hit1}, {31'd0, h1});
        chk("rnd_byp_data1", byp_data1, d1);
        chk("rnd_byp_hit2", {31'd0, byp_hit2}, {31'd0, h2});
        chk("rnd_byp_data2", byp_data2, d2);
        if (pop_h) void'(m_q.pop_front());
        if (md_valid && rdy && md_w_addr != 5'd0) begin
            e.a = md_w_addr; e.d = md_w_data;
            m_q.push_back(e);
        end
        if (cnt == 0 || pop_h) m_starve = 0;
        else if (wbg) m_starve = m_starve + 1;
        m_ready_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            wb_en  wb_addr wb_data      md_v  md_addr md_data      rd1    rd2    e_en  e_addr e_data       e_rdy e_stl e_cnt e_h1  e_d1         e_h2  e_d2
        tv.push_back('{1'b1, 5'd5,  32'h1234,    1'b0, 5'd0,  32'h0,      5'd0,  5'd0,  1'b1, 5'd5,  32'h1234,    1'b1, 1'b0, 2'd0, 1'b0, 32'h0,      1'b0, 32'h0});
        tv.push_back('{1'b0, 5'd0,  32'h0,       1'b1, 5'd7,  32'hAAAA,   5'd0,  5'd0,  1'b0, 5'd0,  32'h0,       1'b1, 1'b0, 2'd0, 1'b0, 32'h0,      1'b0, 32'h0});
        tv.push_back('{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,      5'd7,  5'd0,  1'b1, 5'd7,  32'hAAAA,    1'b1, 1'b0, 2'd1, 1'b1, 32'hAAAA,   1'b0, 32'h0});
        tv.push_back('{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,      5'd7,  5'd0,  1'b0, 5'd0,  32'h0,       1'b1, 1'b0, 2'd0, 1'b0, 32'h0,      1'b0, 32'h0});
        tv.push_back('{1'b1, 5'd10, 32'h10,      1'b1, 5'd3,  32'h300,    5'd3,  5'd3,  1'b1, 5'd10, 32'h10,      1'b1, 1'b0, 2'd0, 1'b0, 32'h0,      1'b0, 32'h0});
        tv.push_back('{1'b1, 5'd11, 32'h11,      1'b1, 5'd3,  32'h301,    5'd3,  5'd10, 1'b1, 5'd11, 32'h11,      1'b1, 1'b0, 2'd1, 1'b1, 32'h300,    1'b0, 32'h0});
        tv.push_back('{1'b1, 5'd12, 32'h12,      1'b1, 5'd9,  32'h999,    5'd3,  5'd3,  1'b1, 5'd12, 32'h12,      1'b0, 1'b0, 2'd2, 1'b1, 32'h301,    1'b1, 32'h301});
        tv.push_back('{1'b1, 5'd13, 32'h13,      1'b0, 5'd0,  32'h0,      5'd3,  5'd9,  1'b1, 5'd13, 32'h13,      1'b0, 1'b0, 2'd2, 1'b1, 32'h301,    1'b0, 32'h0});
        tv.push_back('{1'b1, 5'd14, 32'h14,      1'b0, 5'd0,  32'h0,      5'd3,  5'd0,  1'b1, 5'd14, 32'h14,      1'b0, 1'b0, 2'd2, 1'b1, 32'h301,    1'b0, 32'h0});
        tv.push_back('{1'b1, 5'd15, 32'h15,      1'b0, 5'd0,  32'h0,      5'd3,  5'd3,  1'b1, 5'd3,  32'h300,     1'b0, 1'b1, 2'd2, 1'b1, 32'h301,    1'b1, 32'h301});
        tv.push_back('{1'b1, 5'd15, 32'h15,      1'b0, 5'd0,  32'h0,      5'd3,  5'd0,  1'b1, 5'd15, 32'h15,      1'b1, 1'b0, 2'd1, 1'b1, 32'h301,    1'b0, 32'h0});
        tv.push_back('{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,      5'd3,  5'd3,  1'b1, 5'd3,  32'h301,     1'b1, 1'b0, 2'd1, 1'b1, 32'h301,    1'b1, 32'h301});
        tv.push_back('{1'b1, 5'd0,  32'hDEAD,    1'b1, 5'd0,  32'hBEEF,   5'd0,  5'd0,  1'b0, 5'd0,  32'h0,       1'b1, 1'b0, 2'd0, 1'b0, 32'h0,      1'b0, 32'h0});
        tv.push_back('{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,      5'd0,  5'd0,  1'b0, 5'd0,  32'h0,       1'b1, 1'b0, 2'd0, 1'b0, 32'h0,      1'b0, 32'h0});

        // Reset state, with a WB request pending to prove the write port is gated
        reset = 1'b1;
        drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 5'd5, 5'd6);
        repeat (2) @(posedge clk);
        #4;
        chk("rst_md_ready", {31'd0, md_ready}, 32'd0);
        chk("rst_rf_w_en", {31'd0, rf_w_en}, 32'd0);
        chk("rst_rf_w_addr", {27'd0, rf_w_addr}, 32'd0);
        chk("rst_rf_w_data", rf_w_data, 32'd0);
        chk("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
        chk("rst_byp_hit1", {31'd0, byp_hit1}, 32'd0);
        chk("rst_byp_hit2", {31'd0, byp_hit2}, 32'd0);
        chk("rst_buf_count", 32'(buf_count), 32'd0);

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        reset = 1'b0;
        #1;
        chk("rel_md_ready_before_edge", {31'd0, md_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rel_md_ready_after_edge", {31'd0, md_ready}, 32'd1);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].wb_en, tv[i].wb_addr, tv[i].wb_data, tv[i].md_v, tv[i].md_addr,
                  tv[i].md_data, tv[i].rd1, tv[i].rd2);
            #3;
            chk($sformatf("vec%0d_rf_w_en", i), {31'd0, rf_w_en}, {31'd0, tv[i].e_en});
            if (tv[i].e_en) begin
                chk($sformatf("vec%0d_rf_w_addr", i), {27'd0, rf_w_addr}, {27'd0, tv[i].e_addr});
                chk($sformatf("vec%0d_rf_w_data", i), rf_w_data, tv[i].e_data);
            end
            chk($sformatf("vec%0d_md_ready", i), {31'd0, md_ready}, {31'd0, tv[i].e_rdy});
            chk($sformatf("vec%0d_wb_stall", i), {31'd0, wb_stall}, {31'd0, tv[i].e_stall});
            chk($sformatf("vec%0d_buf_count", i), 32'(buf_count), 32'(tv[i].e_cnt));
            chk($sformatf("vec%0d_byp_hit1", i), {31'd0, byp_hit1}, {31'd0, tv[i].e_h1});
            chk($sformatf("vec%0d_byp_data1", i), byp_data1, tv[i].e_d1);
            chk($sformatf("vec%0d_byp_hit2", i), {31'd0, byp_hit2}, {31'd0, tv[i].e_h2});
            chk($sformatf("vec%0d_byp_data2", i), byp_data2, tv[i].e_d2);
            @(posedge clk); #1;
        end

        // Mid-operation reset with a full buffer
        drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 5'd0, 5'd0);
        @(posedge clk); #1;
        drive(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23, 5'd0, 5'd0);
        @(posedge clk); #1;
        drive(1'b1, 5'd24, 32'h24, 1'b0, 5'd0, 32'h0, 5'd21, 5'd23);
        #3;
        chk("mid_full_count", 32'(buf_count), 32'd2);
        chk("mid_full_md_ready", {31'd0, md_ready}, 32'd0);
        chk("mid_full_hit1", {31'd0, byp_hit1}, 32'd1);
        chk("mid_full_data2", byp_data2, 32'h23);
        reset = 1'b1;
        #1;
        chk("mid_rst_count", 32'(buf_count), 32'd0);
        chk("mid_rst_rf_w_en", {31'd0, rf_w_en}, 32'd0);
        chk("mid_rst_md_ready", {31'd0, md_ready}, 32'd0);
        chk("mid_rst_hit1", {31'd0, byp_hit1}, 32'd0);
        @(posedge clk); #4;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd21, 5'd23);
        reset = 1'b0;
        #1;
        chk("mid_rel_md_ready_before_edge", {31'd0, md_ready}, 32'd0);
        @(posedge clk); #1;
        chk("mid_rel_md_ready", {31'd0, md_ready}, 32'd1);
        chk("mid_rel_count", 32'(buf_count), 32'd0);
        chk("mid_rel_hit1", {31'd0, byp_hit1}, 32'd0);
        chk("mid_rel_hit2", {31'd0, byp_hit2}, 32'd0);

        // Random traffic against the reference model
        m_q.delete();
        m_starve   = 0;
        m_ready_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #3;
            model_cycle();
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
